// File: rtl/wb_arbiter.sv
// Writeback bus arbiter: one holding register per functional unit (ALU/MEM/MUL),
// round-robin grant of one held result per cycle onto a registered result bus.
module wb_arbiter #(
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alu_valid,
  input  logic [WORD_SIZE-1:0]       alu_data,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
  input  logic                       mem_valid,
  input  logic [WORD_SIZE-1:0]       mem_data,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
  input  logic                       mul_valid,
  input  logic [WORD_SIZE-1:0]       mul_data,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
  output logic                       alu_stall,
  output logic                       mem_stall,
  output logic                       mul_stall,
  output logic                       wb_valid,
  output logic [WORD_SIZE-1:0]       wb_data,
  output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
  output logic [1:0]                 wb_src
);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MUL = 2'd2;

  logic [2:0]                 in_valid_s;
  logic [WORD_SIZE-1:0]       in_data_s [0:2];
  logic [ROB_ENTRY_WIDTH-1:0] in_tag_s  [0:2];

  logic [2:0]                 hold_valid_r;
  logic [WORD_SIZE-1:0]       hold_data_r [0:2];
  logic [ROB_ENTRY_WIDTH-1:0] hold_tag_r  [0:2];
  logic [1:0]                 rr_ptr_r;

  logic [2:0]                 grant_s;
  logic [2:0]                 stall_s;
  logic [1:0]                 winner_s;
  logic [1:0]                 scan_s;
  logic                       any_grant_s;

  logic                       wb_valid_r;
  logic [WORD_SIZE-1:0]       wb_data_r;
  logic [ROB_ENTRY_WIDTH-1:0] wb_tag_r;
  logic [1:0]                 wb_src_r;

  assign in_valid_s   = {mul_valid, mem_valid, alu_valid};
  assign in_data_s[0] = alu_data;
  assign in_data_s[1] = mem_data;
  assign in_data_s[2] = mul_data;
  assign in_tag_s[0]  = alu_rob_id;
  assign in_tag_s[1]  = mem_rob_id;
  assign in_tag_s[2]  = mul_rob_id;

  // Round-robin search over held results starting at rr_ptr (a stray 3 aliases to 0)
  always_comb begin
    any_grant_s = 1'b0;
    winner_s    = SRC_ALU;
    scan_s      = (rr_ptr_r == 2'd3) ? 2'd0 : rr_ptr_r;
    for (int i = 0; i < 3; i++) begin
      if (!any_grant_s && hold_valid_r[scan_s]) begin
        any_grant_s = 1'b1;
        winner_s    = scan_s;
      end else begin
        any_grant_s = any_grant_s;
      end
      scan_s = (scan_s == 2'd2) ? 2'd0 : scan_s + 2'd1;
    end
  end

  // One-hot grant vector from the search result
  always_comb begin
    grant_s = 3'b000;
    if (any_grant_s) begin
      grant_s[winner_s] = 1'b1;
    end else begin
      grant_s = 3'b000;
    end
  end

  // A granted slot frees this cycle, so only losers of arbitration stall
  assign stall_s   = hold_valid_r & ~grant_s & {3{~flush}};
  assign alu_stall = stall_s[0];
  assign mem_stall = stall_s[1];
  assign mul_stall = stall_s[2];

  // Holding registers: a new load beats the clear of a just-granted entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        hold_data_r[i] <= {WORD_SIZE{1'b0}};
        hold_tag_r[i]  <= {ROB_ENTRY_WIDTH{1'b0}};
      end
    end else if (flush) begin
      hold_valid_r <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (in_valid_s[i] && !stall_s[i]) begin
          hold_valid_r[i] <= 1'b1;
          hold_data_r[i]  <= in_data_s[i];
          hold_tag_r[i]   <= in_tag_s[i];
        end else if (grant_s[i]) begin
          hold_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Result bus register and round-robin pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_r <= 1'b0;
      wb_data_r  <= {WORD_SIZE{1'b0}};
      wb_tag_r   <= {ROB_ENTRY_WIDTH{1'b0}};
      wb_src_r   <= SRC_ALU;
      rr_ptr_r   <= 2'd0;
    end else if (flush) begin
      wb_valid_r <= 1'b0;
    end else if (any_grant_s) begin
      wb_valid_r <= 1'b1;
      wb_data_r  <= hold_data_r[winner_s];
      wb_tag_r   <= hold_tag_r[winner_s];
      wb_src_r   <= winner_s;
      rr_ptr_r   <= (winner_s == SRC_MUL) ? SRC_ALU : winner_s + 2'd1;
    end else begin
      wb_valid_r <= 1'b0;
    end
  end

  assign wb_valid  = wb_valid_r;
  assign wb_data   = wb_data_r;
  assign wb_rob_id = wb_tag_r;
  assign wb_src    = wb_src_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected bus results are queued as units
// present them and compared in order as the result bus delivers them.
module tb_wb_arbiter;

  localparam int W = 32;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         alu_valid, mem_valid, mul_valid;
  logic [W-1:0] alu_data, mem_data, mul_data;
  logic [T-1:0] alu_rob_id, mem_rob_id, mul_rob_id;
  logic         alu_stall, mem_stall, mul_stall;
  logic         wb_valid;
  logic [W-1:0] wb_data;
  logic [T-1:0] wb_rob_id;
  logic [1:0]   wb_src;

  wb_arbiter #(.WORD_SIZE(W), .ROB_ENTRY_WIDTH(T)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_data(alu_data), .alu_rob_id(alu_rob_id),
    .mem_valid(mem_valid), .mem_data(mem_data), .mem_rob_id(mem_rob_id),
    .mul_valid(mul_valid), .mul_data(mul_data), .mul_rob_id(mul_rob_id),
    .alu_stall(alu_stall), .mem_stall(mem_stall), .mul_stall(mul_stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rob_id(wb_rob_id), .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [63:0] sb_q[$];
  int          log_cyc[$];
  int          log_src[$];
  int          stall_cnt[3] = '{0, 0, 0};
  int          snap[3];
  int          idx0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_data(input int s, input int k);
    return {8'(s + 1), 16'h0000, 8'(k)};
  endfunction

  function automatic logic [63:0] mk_exp(input int s, input int k, input logic [W-1:0] d);
    return 64'({2'(s), 4'(k), d});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: pops the scoreboard, logs grants, counts stall cycles
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_stall) stall_cnt[0] <= stall_cnt[0] + 1;
      if (mem_stall) stall_cnt[1] <= stall_cnt[1] + 1;
      if (mul_stall) stall_cnt[2] <= stall_cnt[2] + 1;
      if (wb_valid) begin
        log_cyc.push_back(cyc);
        log_src.push_back(int'(wb_src));
        if (sb_q.size() == 0) begin
          check("wb_unexpected", 64'(wb_valid), 64'd0);
        end else begin
          check("wb_result", 64'({wb_src, wb_rob_id, wb_data}), sb_q.pop_front());
        end
      end
    end
  end

  // Each unit presents its results in order, holding one while stalled
  task automatic run_units(input int na, input int nm, input int nu);
    int tot[3];
    int k[3];
    bit acc[3];
    int guard;
    tot[0] = na; tot[1] = nm; tot[2] = nu;
    k = '{0, 0, 0};
    guard = 0;
    while ((k[0] < tot[0] || k[1] < tot[1] || k[2] < tot[2]) && guard < 100) begin
      alu_valid = (k[0] < tot[0]); alu_data = mk_data(0, k[0]); alu_rob_id = 4'(k[0]);
      mem_valid = (k[1] < tot[1]); mem_data = mk_data(1, k[1]); mem_rob_id = 4'(k[1]);
      mul_valid = (k[2] < tot[2]); mul_data = mk_data(2, k[2]); mul_rob_id = 4'(k[2]);
      @(negedge clk);
      acc[0] = alu_valid && !alu_stall;
      acc[1] = mem_valid && !mem_stall;
      acc[2] = mul_valid && !mul_stall;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (acc[i]) k[i]++;
      guard++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0; mul_valid = 1'b0;
    check("run_bound", (guard < 100) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 60) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int cnt[3];
    int last[3];
    int gap[3];
    bit ok;
    rst = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; mul_valid = 1'b0;
    alu_data = '0; mem_data = '0; mul_data = '0;
    alu_rob_id = '0; mem_rob_id = '0; mul_rob_id = '0;
    #1;
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_wb_rob_id", 64'(wb_rob_id), 64'd0);
    check("rst_wb_src", 64'(wb_src), 64'd0);
    check("rst_stalls", 64'({alu_stall, mem_stall, mul_stall}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single ALU result: bus valid two cycles after presentation
    alu_valid = 1'b1; alu_data = 32'h0000_00AA; alu_rob_id = 4'd3;
    sb_q.push_back(mk_exp(0, 3, 32'h0000_00AA));
    @(negedge clk);
    check("t1_stall_c0", 64'({alu_stall, mem_stall, mul_stall}), 64'd0);
    @(posedge clk); #1 alu_valid = 1'b0;
    @(negedge clk);
    check("t1_wb_c1", 64'(wb_valid), 64'd0);
    check("t1_stall_c1", 64'({alu_stall, mem_stall, mul_stall}), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_wb_c2", 64'(wb_valid), 64'd1);
    drain();

    // ALU streaming, tags 0..7 back to back
    idx0 = log_src.size();
    snap = stall_cnt;
    for (int k = 0; k < 8; k++) sb_q.push_back(mk_exp(0, k, mk_data(0, k)));
    run_units(8, 0, 0);
    drain();
    check("stream_count", 64'(log_src.size() - idx0), 64'd8);
    ok = 1'b1;
    for (int j = idx0 + 1; j < log_cyc.size(); j++) if (log_cyc[j] != log_cyc[j-1] + 1) ok = 1'b0;
    check("stream_back2back", 64'(ok), 64'd1);
    check("stream_alu_stall", 64'(stall_cnt[0] - snap[0]), 64'd0);

    // Lone MUL result, which also returns the pointer to ALU
    sb_q.push_back(mk_exp(2, 0, mk_data(2, 0)));
    run_units(0, 0, 1);
    drain();

    // Three-way collision from pointer 0
    snap = stall_cnt;
    for (int s = 0; s < 3; s++) sb_q.push_back(mk_exp(s, 0, mk_data(s, 0)));
    run_units(1, 1, 1);
    drain();
    check("coll_alu_stall", 64'(stall_cnt[0] - snap[0]), 64'd0);
    check("coll_mem_stall", 64'(stall_cnt[1] - snap[1]), 64'd1);
    check("coll_mul_stall", 64'(stall_cnt[2] - snap[2]), 64'd2);

    // Fairness: all units busy, grants rotate ALU, MEM, MUL
    idx0 = log_src.size();
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < 3; s++) sb_q.push_back(mk_exp(s, k, mk_data(s, k)));
    run_units(4, 4, 4);
    drain();
    cnt = '{0, 0, 0}; last = '{-1, -1, -1}; gap = '{0, 0, 0};
    for (int j = idx0; j < log_src.size(); j++) begin
      cnt[log_src[j]]++;
      if (last[log_src[j]] >= 0 && log_cyc[j] - last[log_src[j]] > gap[log_src[j]])
        gap[log_src[j]] = log_cyc[j] - last[log_src[j]];
      last[log_src[j]] = log_cyc[j];
    end
    for (int s = 0; s < 3; s++) begin
      check("fair_count", 64'(cnt[s]), 64'd4);
      check("fair_gap_le3", (gap[s] <= 3) ? 64'd1 : 64'd0, 64'd1);
    end

    // Flush with MEM and MUL held, MUL losing arbitration
    idx0 = log_src.size();
    mem_valid = 1'b1; mem_data = mk_data(1, 9); mem_rob_id = 4'd9;
    mul_valid = 1'b1; mul_data = mk_data(2, 9); mul_rob_id = 4'd9;
    @(negedge clk);
    check("fl_stall_c0", 64'({alu_stall, mem_stall, mul_stall}), 64'd0);
    @(posedge clk); #1;
    mem_valid = 1'b0; mul_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("fl_stall_flush", 64'({alu_stall, mem_stall, mul_stall}), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("fl_wb_after", 64'(wb_valid), 64'd0);
    check("fl_stall_after", 64'({alu_stall, mem_stall, mul_stall}), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("fl_no_output", 64'(log_src.size() - idx0), 64'd0);

    // Async reset while the bus is valid and MUL is still held
    mem_valid = 1'b1; mem_data = mk_data(1, 0); mem_rob_id = 4'd0;
    mul_valid = 1'b1; mul_data = mk_data(2, 0); mul_rob_id = 4'd0;
    sb_q.push_back(mk_exp(1, 0, mk_data(1, 0)));
    @(posedge clk); #1;
    mem_valid = 1'b0; mul_valid = 1'b0;
    @(negedge clk);
    check("rs_mul_stall", 64'(mul_stall), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rs_wb_before", 64'(wb_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rs_wb_async", 64'(wb_valid), 64'd0);
    check("rs_src_async", 64'(wb_src), 64'd0);
    check("rs_stalls_async", 64'({alu_stall, mem_stall, mul_stall}), 64'd0);
    @(posedge clk); #3 rst = 1'b0;
    for (int s = 0; s < 3; s++) sb_q.push_back(mk_exp(s, 0, mk_data(s, 0)));
    run_units(1, 1, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single writeback/bypass result bus between the ALU, MEM and MUL functional units.
- Each unit has a one-entry holding register. A round-robin arbiter grants one held result per cycle and drives it onto a registered result bus.
- The result bus feeds the ROB write port and the forward unit's bypass inputs.
- When a unit's held result loses arbitration, the block returns a per-unit stall to that unit.

Parameters:
- WORD_SIZE, 32, result data width.
- ROB_ENTRY_WIDTH, 4, ROB entry tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous pipeline flush (mispredict/exception).
- alu_valid  in  1  ALU presents a result.
- alu_data  in  WORD_SIZE  ALU result.
- alu_rob_id  in  ROB_ENTRY_WIDTH  ALU result tag.
- mem_valid / mem_data / mem_rob_id  in  1 / WORD_SIZE / ROB_ENTRY_WIDTH  same as ALU, for the MEM unit.
- mul_valid / mul_data / mul_rob_id  in  1 / WORD_SIZE / ROB_ENTRY_WIDTH  same as ALU, for the MUL unit.
- alu_stall, mem_stall, mul_stall  out  1 each  unit must hold its valid/data/rob_id stable this cycle.
- wb_valid  out  1  result bus carries a valid result.
- wb_data  out  WORD_SIZE  result value.
- wb_rob_id  out  ROB_ENTRY_WIDTH  result tag.
- wb_src  out  2  source of the result on the bus: 0=ALU, 1=MEM, 2=MUL.

Behaviour:
- Reset (async, rst high):
  - hold_valid[ALU/MEM/MUL]=0; hold data/tag=0.
  - wb_valid=0, wb_data=0, wb_rob_id=0, wb_src=0.
  - rr_ptr=0.
  - All stalls read 0 once reset is applied.
- Holding registers: one per source, each holding {valid, data, rob_id}.
- Arbitration (combinational, each cycle):
  - Candidates are the sources with hold_valid=1.
  - Search order starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). The first candidate found is granted.
  - At most one grant per cycle.
- Stall (combinational): src_stall = hold_valid[src] && !grant[src] && !flush.
  - A granted source is never stalled, so its freed slot can accept a new result in the same cycle.
- Capture at the clock edge, for each source when not flushing:
  - If src_valid && !src_stall: load the hold register with the new result.
  - Else if grant[src]: clear hold_valid[src].
  - Else: keep the current contents.
  - A stalled source's input is not sampled. The unit re-presents the same result, which is captured on the cycle its stall drops.
- Output register, updated at the edge:
  - With a grant: wb_valid=1, wb_data/wb_rob_id from the winner's hold register, wb_src=winner.
  - Without a grant: wb_valid=0; wb_data/wb_rob_id/wb_src keep their previous values.
- rr_ptr update: on a grant, rr_ptr = (winner+1) mod 3; otherwise unchanged. rr_ptr is never 3; if it reaches 3 it is treated as 0.
- Latency:
  - Uncontended: input valid in cycle t, captured at the end of t, granted in t+1, wb_valid=1 in t+2.
  - Throughput is one result per cycle.
- Fairness: with all three sources continuously busy, grants rotate ALU→MEM→MUL. Each source waits at most 2 cycles between grants.
- Flush:
  - At the next edge, all hold_valid and wb_valid become 0.
  - Inputs and any grant in the flush cycle are discarded.
  - rr_ptr is unchanged.
  - Stalls are forced to 0 during the flush cycle.
- Simultaneous load and grant on the same source: the load wins, so the new entry replaces the granted one (back-to-back results from one unit).
- Reset asserted mid-operation: all state is cleared immediately, regardless of clk.

Test Plan:
- Reset, then a single ALU result: alu_valid=1, data=0x0000_00AA, rob_id=3 for 1 cycle → 2 cycles later wb_valid=1, wb_data=0xAA, wb_rob_id=3, wb_src=0. No stall is asserted.
- Three-way collision, rr_ptr=0: ALU (0x11, id 1), MEM (0x22, id 2) and MUL (0x33, id 5) all valid in the same cycle and held while stalled → wb sequence on three consecutive cycles is ALU, MEM, MUL.
  - mem_stall is high for 1 cycle; mul_stall is high for 2 cycles.
  - rr_ptr ends at 0.
- Continuous streaming from ALU only, with a new rob_id each cycle (0..7) → wb_valid held at 1 for 8 consecutive cycles with tags 0..7 in order. alu_stall stays 0 throughout.
- Fairness: all three sources present a new result every cycle for 12 cycles → each source is granted exactly 4 times, with no gap longer than 2 cycles per source.
- Flush: MEM and MUL held with MUL stalled; assert flush for 1 cycle → next cycle wb_valid=0 and all stalls are 0. No MEM or MUL result appears afterwards unless it is re-presented.
- Async reset mid-stream: assert rst between clock edges while wb_valid=1 → wb_valid drops to 0 immediately, and the first post-reset grant goes to the ALU when all sources request.
